// File: rtl/vec_add_if.sv
// Operand/result handshake bundle for vec_add_sequencer: operand pair in, sum vector out.
interface vec_add_if #(
  parameter int WORD_WIDTH  = 31,
  parameter int VECTOR_SIZE = 16
);
  logic                  in_valid;
  logic                  in_ready;
  logic [WORD_WIDTH-1:0] vec1   [0:VECTOR_SIZE-1];
  logic [WORD_WIDTH-1:0] vec2   [0:VECTOR_SIZE-1];
  logic                  out_valid;
  logic                  out_ready;
  logic [WORD_WIDTH-1:0] result [0:VECTOR_SIZE-1];
  logic                  busy;

  modport master (
    output in_valid, vec1, vec2, out_ready,
    input  in_ready, out_valid, result, busy
  );

  modport slave (
    input  in_valid, vec1, vec2, out_ready,
    output in_ready, out_valid, result, busy
  );
endinterface

// File: rtl/vec_add_sequencer.sv
// M31 vector addition folded onto a LANES-wide shared adder, one chunk per cycle.
// Operands are captured on the input handshake; the sum is held until taken downstream.
module m31_adder #(
  parameter int WORD_WIDTH = 31
) (
  input  logic [WORD_WIDTH-1:0] a,
  input  logic [WORD_WIDTH-1:0] b,
  output logic [WORD_WIDTH-1:0] sum
);
  localparam logic [WORD_WIDTH:0] P = {1'b0, {WORD_WIDTH{1'b1}}};

  logic [WORD_WIDTH:0] raw;
  logic [WORD_WIDTH:0] red;

  assign raw = {1'b0, a} + {1'b0, b};
  assign red = raw - P;
  assign sum = (raw >= P) ? red[WORD_WIDTH-1:0] : raw[WORD_WIDTH-1:0];
endmodule

module vector_adder #(
  parameter int WORD_WIDTH = 31,
  parameter int LANES      = 4
) (
  input  logic [LANES-1:0][WORD_WIDTH-1:0] a,
  input  logic [LANES-1:0][WORD_WIDTH-1:0] b,
  output logic [LANES-1:0][WORD_WIDTH-1:0] sum
);
  for (genvar j = 0; j < LANES; j++) begin : g_lane
    m31_adder #(.WORD_WIDTH(WORD_WIDTH)) u_add (
      .a  (a[j]),
      .b  (b[j]),
      .sum(sum[j])
    );
  end
endmodule

module vec_add_sequencer #(
  parameter int WORD_WIDTH  = 31,
  parameter int VECTOR_SIZE = 16,
  parameter int LANES       = 4
) (
  input  logic      clk,
  input  logic      rst,
  vec_add_if.slave  bus
);
  localparam int N  = VECTOR_SIZE / LANES;
  localparam int KW = (N > 1) ? $clog2(N) : 1;
  localparam int IW = (VECTOR_SIZE > 1) ? $clog2(VECTOR_SIZE) : 1;

  if (VECTOR_SIZE % LANES != 0) begin : g_bad_lanes
    $error("vec_add_sequencer: VECTOR_SIZE must be a multiple of LANES");
  end

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t                state_q;
  logic [KW-1:0]         k_q;
  logic                  out_valid_q;
  logic                  busy_q;
  logic [WORD_WIDTH-1:0] op1_q [0:VECTOR_SIZE-1];
  logic [WORD_WIDTH-1:0] op2_q [0:VECTOR_SIZE-1];
  logic [WORD_WIDTH-1:0] res_q [0:VECTOR_SIZE-1];

  logic [LANES-1:0][WORD_WIDTH-1:0] a_chunk, b_chunk, s_chunk;
  logic                             accept;

  // in_ready is decoded from state; in DONE it follows out_ready so a new pair can ride the drain.
  assign bus.in_ready  = !rst && ((state_q == IDLE) || ((state_q == DONE) && bus.out_ready));
  assign accept        = bus.in_valid && bus.in_ready;
  assign bus.out_valid = out_valid_q;
  assign bus.busy      = busy_q;
  assign bus.result    = res_q;

  // NOTE: every variable gets a default at the top of always_comb so no latch is inferred.
  always_comb begin
    a_chunk = '0;
    b_chunk = '0;
    for (int j = 0; j < LANES; j++) begin
      a_chunk[j] = op1_q[IW'(int'(k_q) * LANES + j)];
      b_chunk[j] = op2_q[IW'(int'(k_q) * LANES + j)];
    end
  end

  vector_adder #(.WORD_WIDTH(WORD_WIDTH), .LANES(LANES)) u_vadd (
    .a  (a_chunk),
    .b  (b_chunk),
    .sum(s_chunk)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      k_q         <= '0;
      out_valid_q <= 1'b0;
      busy_q      <= 1'b0;
      // NOTE: the buffers are cleared on reset because a post-reset result must read as zero.
      for (int i = 0; i < VECTOR_SIZE; i++) begin
        op1_q[i] <= '0;
        op2_q[i] <= '0;
        res_q[i] <= '0;
      end
    end else begin
      if (accept) begin
        for (int i = 0; i < VECTOR_SIZE; i++) begin
          op1_q[i] <= bus.vec1[i];
          op2_q[i] <= bus.vec2[i];
        end
      end
      case (state_q)
        IDLE: begin
          if (accept) begin
            state_q <= RUN;
            k_q     <= '0;
            busy_q  <= 1'b1;
          end
        end
        RUN: begin
          for (int j = 0; j < LANES; j++) begin
            res_q[IW'(int'(k_q) * LANES + j)] <= s_chunk[j];
          end
          if (k_q == KW'(N - 1)) begin
            state_q     <= DONE;
            k_q         <= '0;
            out_valid_q <= 1'b1;
          end else begin
            k_q <= k_q + 1'b1;
          end
        end
        DONE: begin
          if (bus.out_ready) begin
            out_valid_q <= 1'b0;
            k_q         <= '0;
            if (bus.in_valid) begin
              state_q <= RUN;
            end else begin
              state_q <= IDLE;
              busy_q  <= 1'b0;
            end
          end
        end
        default: begin
          state_q     <= IDLE;
          out_valid_q <= 1'b0;
          busy_q      <= 1'b0;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_vec_add_sequencer.sv
// Directed bench for vec_add_sequencer: default LANES=4 plus LANES=16 and LANES=1 instances.
module tb_vec_add_sequencer;
  localparam int W  = 31;
  localparam int VS = 16;
  localparam longint P = 64'd2147483647;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  vec_add_if #(.WORD_WIDTH(W), .VECTOR_SIZE(VS)) b4  ();
  vec_add_if #(.WORD_WIDTH(W), .VECTOR_SIZE(VS)) b16 ();
  vec_add_if #(.WORD_WIDTH(W), .VECTOR_SIZE(VS)) b1  ();

  vec_add_sequencer #(.WORD_WIDTH(W), .VECTOR_SIZE(VS), .LANES(4))  dut4  (.clk(clk), .rst(rst), .bus(b4));
  vec_add_sequencer #(.WORD_WIDTH(W), .VECTOR_SIZE(VS), .LANES(16)) dut16 (.clk(clk), .rst(rst), .bus(b16));
  vec_add_sequencer #(.WORD_WIDTH(W), .VECTOR_SIZE(VS), .LANES(1))  dut1  (.clk(clk), .rst(rst), .bus(b1));

  int n_assert = 0;
  int n_fail   = 0;

  logic [W-1:0] va [0:VS-1];
  logic [W-1:0] vb [0:VS-1];
  logic [W-1:0] vc [0:VS-1];
  logic [W-1:0] vd [0:VS-1];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  function automatic logic [W-1:0] mod_add(input logic [W-1:0] a, input logic [W-1:0] b);
    longint s;
    s = (longint'(a) + longint'(b)) % P;
    return s[W-1:0];
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic load4(input logic [W-1:0] x [0:VS-1], input logic [W-1:0] y [0:VS-1]);
    for (int i = 0; i < VS; i++) begin
      b4.vec1[i] = x[i];
      b4.vec2[i] = y[i];
    end
  endtask

  // Count edges until dut4 shows out_valid, bounded so a stuck design still reaches the summary.
  task automatic wait_valid4(output int cyc);
    cyc = 0;
    do begin
      step();
      cyc++;
    end while (!b4.out_valid && cyc < 60);
  endtask

  task automatic check_result4(input string tag, input logic [W-1:0] x [0:VS-1], input logic [W-1:0] y [0:VS-1]);
    for (int i = 0; i < VS; i++) begin
      check($sformatf("%s[%0d]", tag, i), 32'(b4.result[i]), 32'(mod_add(x[i], y[i])));
    end
  endtask

  initial begin
    int cyc, lat16, lat1, all_zero, stale;

    rst = 1'b1;
    b4.in_valid = 1'b0;  b4.out_ready = 1'b0;
    b16.in_valid = 1'b0; b16.out_ready = 1'b0;
    b1.in_valid = 1'b0;  b1.out_ready = 1'b0;
    for (int i = 0; i < VS; i++) begin
      va[i] = '0; vb[i] = '0;
    end
    load4(va, vb);
    for (int i = 0; i < VS; i++) begin
      b16.vec1[i] = '0; b16.vec2[i] = '0; b1.vec1[i] = '0; b1.vec2[i] = '0;
    end

    // Reset state
    step();
    step();
    check("rst_in_ready_low", 32'(b4.in_ready), 32'd0);
    check("rst_out_valid", 32'(b4.out_valid), 32'd0);
    check("rst_busy", 32'(b4.busy), 32'd0);
    check("rst_result0", 32'(b4.result[0]), 32'd0);
    check("rst_result15", 32'(b4.result[15]), 32'd0);
    rst = 1'b0;
    #1;
    check("idle_in_ready", 32'(b4.in_ready), 32'd1);

    // Single vector: vec1[i]=i, vec2[i]=2i
    for (int i = 0; i < VS; i++) begin
      va[i] = W'(i); vb[i] = W'(2 * i);
    end
    load4(va, vb);
    b4.out_ready = 1'b1;
    b4.in_valid  = 1'b1;
    step();
    b4.in_valid = 1'b0;
    check("run_in_ready", 32'(b4.in_ready), 32'd0);
    check("run_busy", 32'(b4.busy), 32'd1);
    check("run_out_valid", 32'(b4.out_valid), 32'd0);
    wait_valid4(cyc);
    check("single_latency", 32'(cyc), 32'd4);
    check("single_res3", 32'(b4.result[3]), 32'd9);
    check("single_res15", 32'(b4.result[15]), 32'd45);
    check_result4("single", va, vb);
    step();
    check("single_drain_valid", 32'(b4.out_valid), 32'd0);
    check("single_drain_busy", 32'(b4.busy), 32'd0);
    check("single_drain_in_ready", 32'(b4.in_ready), 32'd1);

    // Modular wrap, then backpressure with upstream scribbling on vec1
    for (int i = 0; i < VS; i++) begin
      va[i] = W'(1000 * i); vb[i] = W'(P - 1 - longint'(i));
    end
    va[0] = W'(P - 1); vb[0] = W'(3);
    va[15] = W'(P - 1); vb[15] = W'(1);
    load4(va, vb);
    b4.out_ready = 1'b0;
    b4.in_valid  = 1'b1;
    step();
    b4.in_valid = 1'b0;
    wait_valid4(cyc);
    check("wrap_latency", 32'(cyc), 32'd4);
    check("wrap_res0", 32'(b4.result[0]), 32'd2);
    check("wrap_res15", 32'(b4.result[15]), 32'd0);
    check_result4("wrap", va, vb);
    for (int c = 0; c < 10; c++) begin
      for (int i = 0; i < VS; i++) b4.vec1[i] = W'($urandom_range(0, 1000000));
      step();
      check($sformatf("bp_valid_%0d", c), 32'(b4.out_valid), 32'd1);
      check($sformatf("bp_in_ready_%0d", c), 32'(b4.in_ready), 32'd0);
      check($sformatf("bp_res0_%0d", c), 32'(b4.result[0]), 32'd2);
      check($sformatf("bp_res7_%0d", c), 32'(b4.result[7]), 32'(mod_add(va[7], vb[7])));
    end
    check_result4("bp_end", va, vb);
    b4.out_ready = 1'b1;
    #1;
    check("bp_release_in_ready", 32'(b4.in_ready), 32'd1);
    step();
    check("bp_drain_valid", 32'(b4.out_valid), 32'd0);

    // Back-to-back: vc then vd, second accepted during first drain
    for (int i = 0; i < VS; i++) begin
      vc[i] = W'(7 * i + 5); vd[i] = W'(P - 10 + longint'(i % 8));
    end
    load4(vc, vd);
    b4.in_valid = 1'b1;
    step();
    load4(vd, vc);
    wait_valid4(cyc);
    check("b2b_first_latency", 32'(cyc), 32'd4);
    check_result4("b2b_first", vc, vd);
    check("b2b_in_ready_done", 32'(b4.in_ready), 32'd1);
    step();
    b4.in_valid = 1'b0;
    check("b2b_rerun_busy", 32'(b4.busy), 32'd1);
    check("b2b_rerun_valid", 32'(b4.out_valid), 32'd0);
    cyc = 1;
    while (!b4.out_valid && cyc < 60) begin
      step();
      cyc++;
    end
    check("b2b_second_gap", 32'(cyc), 32'd5);
    check_result4("b2b_second", vd, vc);
    step();
    check("b2b_idle", 32'(b4.in_ready), 32'd1);

    // Reset at k=2 (after the second RUN edge)
    for (int i = 0; i < VS; i++) begin
      va[i] = W'(i + 100); vb[i] = W'(i + 200);
    end
    load4(va, vb);
    b4.in_valid = 1'b1;
    step();
    b4.in_valid = 1'b0;
    step();
    step();
    rst = 1'b1;
    #1;
    check("midrun_rst_in_ready", 32'(b4.in_ready), 32'd0);
    step();
    rst = 1'b0;
    check("midrun_out_valid", 32'(b4.out_valid), 32'd0);
    check("midrun_busy", 32'(b4.busy), 32'd0);
    all_zero = 1;
    for (int i = 0; i < VS; i++) if (b4.result[i] !== '0) all_zero = 0;
    check("midrun_result_zero", 32'(all_zero), 32'd1);
    #1;
    check("midrun_in_ready", 32'(b4.in_ready), 32'd1);
    stale = 0;
    for (int c = 0; c < 10; c++) begin
      step();
      if (b4.out_valid !== 1'b0) stale = 1;
    end
    check("midrun_no_stale", 32'(stale), 32'd0);

    // Parameter sweep: LANES=16 and LANES=1 with random vectors
    for (int i = 0; i < VS; i++) begin
      va[i] = W'($urandom_range(0, 32'h7FFF_FFFE));
      vb[i] = W'($urandom_range(0, 32'h7FFF_FFFE));
      b16.vec1[i] = va[i]; b16.vec2[i] = vb[i];
      b1.vec1[i]  = va[i]; b1.vec2[i]  = vb[i];
    end
    va[3] = W'(P - 1); vb[3] = W'(P - 1);
    b16.vec1[3] = va[3]; b16.vec2[3] = vb[3];
    b1.vec1[3]  = va[3]; b1.vec2[3]  = vb[3];
    b16.in_valid = 1'b1;
    b1.in_valid  = 1'b1;
    step();
    b16.in_valid = 1'b0;
    b1.in_valid  = 1'b0;
    lat16 = 0;
    lat1  = 0;
    for (int c = 1; c <= 40; c++) begin
      step();
      if (lat16 == 0 && b16.out_valid === 1'b1) lat16 = c;
      if (lat1 == 0 && b1.out_valid === 1'b1) lat1 = c;
    end
    check("sweep16_latency", 32'(lat16), 32'd1);
    check("sweep1_latency", 32'(lat1), 32'd16);
    for (int i = 0; i < VS; i++) begin
      check($sformatf("sweep16[%0d]", i), 32'(b16.result[i]), 32'(mod_add(va[i], vb[i])));
      check($sformatf("sweep1[%0d]", i), 32'(b1.result[i]), 32'(mod_add(va[i], vb[i])));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule

// File: doc/vec_add_sequencer.md
# vec_add_sequencer

Folds a VECTOR_SIZE-element M31 vector addition onto a narrower shared `vector_adder` instance of LANES lanes, processing one chunk per cycle. It accepts an operand pair over a valid/ready handshake, captures both operands, sequences the chunks through the adder, and collects the lane results into a result buffer. It presents the complete sum vector over a second valid/ready handshake. It sits between the vector-op issue logic and the arithmetic units, trading adder area for latency.

## Interface
- WORD_WIDTH, 31: element width in bits (M31 field element).
- VECTOR_SIZE, 16: elements per vector.
- LANES, 4: width of the internal `vector_adder` instance.
  - VECTOR_SIZE % LANES != 0 is an elaboration error.
  - N = VECTOR_SIZE/LANES chunks.
- clk  in  1  single clock; all state updates on its rising edge.
- rst  in  1  synchronous, active-high reset.
- in_valid  in  1  operand pair valid.
- in_ready  out  1  block can accept an operand pair this cycle.
- vec1  in  WORD_WIDTH x [0:VECTOR_SIZE-1]  first operand.
- vec2  in  WORD_WIDTH x [0:VECTOR_SIZE-1]  second operand.
- out_valid  out  1  result holds a complete sum.
- out_ready  in  1  downstream takes the result this cycle.
- result  out  WORD_WIDTH x [0:VECTOR_SIZE-1]  registered element-wise sum.
- busy  out  1  high in RUN or DONE.

## Operation
- States:
  - IDLE: no work; in_ready=1.
  - RUN: chunk counter k in 0..N-1.
  - DONE: out_valid=1.
- Input handshake (in_valid && in_ready):
  - Registers vec1/vec2 into operand buffers, sets k=0, enters RUN.
  - Upstream may change the inputs from the next cycle on.
- RUN, each cycle:
  - Drives lanes [k*LANES +: LANES] of both operand buffers into the internal `vector_adder`.
  - Writes its LANES outputs into result buffer slots [k*LANES +: LANES].
  - k increments; when k==N-1, moves to DONE instead.
- Arithmetic: each element equals the `m31_adder` lane output truncated to WORD_WIDTH bits (canonical mod p = 2^31-1). The block adds no extra reduction or carry.
- DONE:
  - result is held stable and out_valid stays high until out_ready.
  - On out handshake: if in_valid is also high, the new pair is accepted in the same cycle (in_ready = out_ready in DONE) and the block goes to RUN. Otherwise it goes to IDLE.
- In RUN, in_ready=0 and in_valid is ignored.
- out_ready outside DONE is ignored.
- result buffer keeps the last sum after leaving DONE. Entering RUN overwrites it chunk by chunk; result is only meaningful while out_valid=1.
- N=1 (LANES==VECTOR_SIZE): RUN lasts exactly one cycle.

## Timing
- Reset values (cycle after rst high):
  - State IDLE, k=0, out_valid=0, busy=0, in_ready=1.
  - result buffer and operand buffers all zero.
  - While rst is high, in_ready=0.
- Latency: handshake at edge t, then RUN during cycles t+1..t+N, then out_valid=1 from cycle t+N+1.
- Throughput:
  - N+1 cycles per vector with out_ready held high and back-to-back in_valid.
  - N+2 cycles per vector via IDLE.
- Reset mid-RUN or mid-DONE: the operation is discarded, no out_valid pulse, and outputs return to reset values on the next edge.
- in_ready and out_valid depend only on state (plus out_ready for in_ready in DONE). There is no combinational path from in_valid to any output.

## Test plan
- Single vector, default params:
  - Stimulus: vec1[i]=i, vec2[i]=2i, out_ready=1.
  - Response: out_valid rises 4 cycles after the handshake edge; result[i]=3i; then back to IDLE with in_ready=1.
- Modular wrap:
  - Stimulus: vec1[0]=2^31-2, vec2[0]=3; vec1[15]=2^31-2, vec2[15]=1.
  - Response: result[0]=2, result[15]=0 (p reduces to 0).
- Backpressure:
  - Stimulus: hold out_ready=0 for 10 cycles after out_valid.
  - Response: result and out_valid stable throughout, in_ready=0; upstream changes to vec1 during this time have no effect.
- Back-to-back:
  - Stimulus: two vectors offered continuously with out_ready=1.
  - Response: the second is accepted in the same cycle the first result is taken; second out_valid appears 5 cycles after the first.
- Reset mid-RUN:
  - Stimulus: assert rst at k=2 for one cycle.
  - Response: next cycle IDLE, out_valid=0, result all zero, and no stale result ever appears.
- Parameter sweep:
  - Stimulus: LANES=16 and LANES=1 with random vectors.
  - Response: latency 1 and 16 cycles respectively; results match a mod-p reference model.
